// File: rtl/keccak_pkg.sv
// Shared Keccak definitions: hash-length encodings, word counts, FSM states.
package keccak_pkg;

  localparam logic [1:0] SIZE_512 = 2'b00;
  localparam logic [1:0] SIZE_384 = 2'b01;
  localparam logic [1:0] SIZE_256 = 2'b10;
  localparam logic [1:0] SIZE_224 = 2'b11;

  localparam logic [4:0] WORDS_512 = 5'd16;
  localparam logic [4:0] WORDS_384 = 5'd12;
  localparam logic [4:0] WORDS_256 = 5'd8;
  localparam logic [4:0] WORDS_224 = 5'd7;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_e;

  // Number of 32-bit digest words for a given hash length.
  function automatic logic [4:0] size_to_words(input logic [1:0] sz);
    logic [4:0] n;
    n = WORDS_512;
    case (sz)
      SIZE_512: n = WORDS_512;
      SIZE_384: n = WORDS_384;
      SIZE_256: n = WORDS_256;
      SIZE_224: n = WORDS_224;
      default:  n = WORDS_512;
    endcase
    return n;
  endfunction

  // Sponge bitrate for a given hash length (used by the input padder).
  function automatic logic [10:0] size_to_rate(input logic [1:0] sz);
    logic [10:0] r;
    r = 11'd576;
    case (sz)
      SIZE_512: r = 11'd576;
      SIZE_384: r = 11'd832;
      SIZE_256: r = 11'd1088;
      SIZE_224: r = 11'd1152;
      default:  r = 11'd576;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keccak_digest_serializer_if.sv
// Digest capture and word-stream signals between permutation core, serializer and user.
interface keccak_digest_serializer_if #(
  parameter int unsigned DIGEST_W = 512,
  parameter int unsigned WORD_W   = 32
);
  logic [DIGEST_W-1:0] f_out;
  logic                f_valid;
  logic                f_ack;
  logic [1:0]          out_size;
  logic                abort;
  logic [WORD_W-1:0]   out;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic                busy;

  // Serializer view.
  modport slave (
    input  f_out, f_valid, out_size, abort, out_ready,
    output f_ack, out, out_valid, out_last, busy
  );

  // Permutation core / user view.
  modport master (
    output f_out, f_valid, out_size, abort, out_ready,
    input  f_ack, out, out_valid, out_last, busy
  );
endinterface

// File: rtl/keccak_digest_serializer.sv
// Captures the final Keccak digest and streams it MSB-first as WORD_W-bit words.
module keccak_digest_serializer
  import keccak_pkg::*;
#(
  parameter int unsigned DIGEST_W = 512,
  parameter int unsigned WORD_W   = 32
) (
  input  logic clk,
  input  logic reset_n,
  keccak_digest_serializer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DIGEST_W / WORD_W + 1);

  ser_state_e          state_q, state_d;
  logic [DIGEST_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ack_q, ack_d;
  logic                xfer;

  assign xfer = (state_q == SEND) && bus.out_ready;

  // State, shift register, word counter and ack pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end

  // Next-state: capture on f_valid, shift per transfer, abort flushes.
  // out_size is only consumed at capture; the loaded counter carries the
  // selected length for the rest of the digest.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.f_valid) begin
            state_d = SEND;
            shift_d = bus.f_out;
            cnt_d   = CNT_W'(size_to_words(bus.out_size));
            ack_d   = 1'b1;
          end
        end
        SEND: begin
          if (xfer) begin
            shift_d = shift_q << WORD_W;
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CNT_W'(1);
            end
            if (cnt_q == CNT_W'(1)) begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.f_ack     = ack_q;
  assign bus.out       = shift_q[DIGEST_W-1 -: WORD_W];
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_last  = (state_q == SEND) && (cnt_q == CNT_W'(1));
  assign bus.busy      = (state_q == SEND);

endmodule

// File: tb/tb_keccak_digest_serializer.sv
// Directed scoreboard bench for keccak_digest_serializer.
module tb_keccak_digest_serializer;

  typedef struct {
    logic [31:0] w;
    logic        last;
  } exp_t;

  logic clk;
  logic reset_n;
  int   passed;
  int   failed;
  int   total;
  exp_t sb[$];
  logic [31:0] first_w;
  logic [31:0] last_w;
  logic [511:0] p1;
  logic [511:0] p2;
  logic [511:0] p3;
  int   got;

  keccak_digest_serializer_if #(.DIGEST_W(512), .WORD_W(32)) bus ();

  keccak_digest_serializer #(.DIGEST_W(512), .WORD_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int words_for(input logic [1:0] sz);
    case (sz)
      2'b00:   return 16;
      2'b01:   return 12;
      2'b10:   return 8;
      default: return 7;
    endcase
  endfunction

  task automatic push_exp(input logic [511:0] d, input logic [1:0] sz);
    exp_t e;
    int n;
    n = words_for(sz);
    for (int k = 0; k < n; k++) begin
      e.w    = d[511-32*k -: 32];
      e.last = (k == n - 1);
      sb.push_back(e);
    end
  endtask

  task automatic start(input logic [511:0] d, input logic [1:0] sz, input bit keep);
    bus.f_out    = d;
    bus.out_size = sz;
    bus.f_valid  = 1'b1;
    push_exp(d, sz);
    chk("ack_before_edge", bus.f_ack, 0);
    step();
    chk("f_ack_pulse", bus.f_ack, 1);
    chk("first_valid", bus.out_valid, 1);
    chk("busy_send", bus.busy, 1);
    bus.f_valid = keep;
  endtask

  // mode 0: always ready; mode 1: ready pattern 1,0,0 repeating.
  task automatic stream(input int mode, input int max_words, input int budget, output int n_got);
    int   cyc;
    bit   held;
    bit   rdy;
    logic [31:0] hw;
    exp_t e;
    cyc   = 0;
    n_got = 0;
    held  = 0;
    hw    = '0;
    while (sb.size() > 0 && n_got < max_words && cyc < budget) begin
      rdy = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      bus.out_ready = rdy;
      if (cyc > 0) chk("f_ack_low_in_send", bus.f_ack, 0);
      chk("valid_in_send", bus.out_valid, 1);
      if (held) chk("hold_word", bus.out, hw);
      e = sb[0];
      chk("word", bus.out, e.w);
      chk("last", bus.out_last, e.last);
      if (cyc == 0) first_w = bus.out;
      if (rdy) begin
        if (e.last) last_w = bus.out;
        void'(sb.pop_front());
        n_got++;
        held = 0;
      end else begin
        held = 1;
        hw   = bus.out;
      end
      step();
      cyc++;
    end
    chk("stream_budget", (cyc < budget), 1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    passed = 0;
    failed = 0;
    total  = 0;
    reset_n       = 1'b0;
    bus.f_out     = '0;
    bus.f_valid   = 1'b0;
    bus.out_size  = 2'b00;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 64; i++) p1[511-8*i -: 8] = 8'(i);
    for (int i = 0; i < 16; i++) p2[511-32*i -: 32] = $urandom;
    for (int i = 0; i < 16; i++) p3[511-32*i -: 32] = $urandom;

    step();
    step();
    chk("rst_f_ack", bus.f_ack, 0);
    chk("rst_out", bus.out, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_busy", bus.busy, 0);
    reset_n = 1'b1;
    step();
    chk("idle_valid", bus.out_valid, 0);

    // 1: 512-bit digest, always ready
    start(p1, 2'b00, 0);
    stream(0, 100, 100, got);
    chk("t1_count", got, 16);
    chk("t1_first", first_w, 32'h00010203);
    chk("t1_last", last_w, 32'h3C3D3E3F);
    chk("t1_valid_after", bus.out_valid, 0);
    chk("t1_busy_after", bus.busy, 0);

    // 2: 224-bit digest
    step();
    start(p1, 2'b11, 0);
    stream(0, 100, 100, got);
    chk("t2_count", got, 7);
    chk("t2_last", last_w, 32'h18191A1B);
    chk("t2_valid_after", bus.out_valid, 0);

    // 3: 256-bit digest with backpressure
    step();
    start(p2, 2'b10, 0);
    stream(1, 100, 100, got);
    chk("t3_count", got, 8);
    chk("t3_valid_after", bus.out_valid, 0);

    // 4: 384-bit digest, f_valid held through SEND with next digest on f_out
    step();
    start(p1, 2'b01, 1);
    bus.f_out = p2;
    stream(0, 100, 100, got);
    chk("t4_count", got, 12);
    chk("t4_gap_valid", bus.out_valid, 0);
    chk("t4_gap_ack", bus.f_ack, 0);
    push_exp(p2, 2'b01);
    step();
    chk("t4_second_ack", bus.f_ack, 1);
    chk("t4_second_valid", bus.out_valid, 1);
    bus.f_valid = 1'b0;
    stream(0, 100, 100, got);
    chk("t4_second_count", got, 12);
    chk("t4_second_first", first_w, p2[511 -: 32]);

    // 5: abort after 3 words, then abort coincident with f_valid, then fresh digest
    step();
    start(p1, 2'b00, 0);
    stream(0, 3, 50, got);
    chk("t5_partial", got, 3);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("t5_valid_abort", bus.out_valid, 0);
    chk("t5_busy_abort", bus.busy, 0);
    chk("t5_last_abort", bus.out_last, 0);
    sb.delete();
    bus.f_out   = p3;
    bus.f_valid = 1'b1;
    bus.abort   = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("t5_no_ack_on_abort", bus.f_ack, 0);
    chk("t5_no_busy_on_abort", bus.busy, 0);
    start(p3, 2'b00, 0);
    stream(0, 100, 100, got);
    chk("t5_fresh_count", got, 16);
    chk("t5_fresh_first", first_w, p3[511 -: 32]);

    // 6: asynchronous reset mid-SEND
    step();
    start(p2, 2'b00, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_ack_drop", bus.f_ack, 0);
    chk("t6_valid_drop", bus.out_valid, 0);
    chk("t6_busy_drop", bus.busy, 0);
    chk("t6_out_drop", bus.out, 0);
    #3;
    reset_n = 1'b1;
    sb.delete();
    step();
    step();
    chk("t6_idle_valid", bus.out_valid, 0);
    chk("t6_idle_ack", bus.f_ack, 0);
    chk("t6_idle_busy", bus.busy, 0);
    start(p1, 2'b11, 0);
    stream(0, 100, 100, got);
    chk("t6_recover_count", got, 7);
    chk("t6_recover_last", last_w, 32'h18191A1B);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/keccak_digest_serializer.md
Name: keccak_digest_serializer

Overview:
Output-side counterpart of the Keccak input padder. Captures the final digest from the f_permutation state after the last absorbed block has been permuted and streams it to the user as 32-bit words over a valid/ready handshake. The word count follows the selected hash length (out_size), and the last word is flagged. It sits between the permutation core and the user/bus interface of the SHA-3 accelerator.

Parameters:
DIGEST_W, 512, width of the digest input bus in bits; must be a multiple of WORD_W.
WORD_W, 32, width of each output word in bits.

Ports:
clk  input  1  clock; all state changes on its rising edge.
reset_n  input  1  asynchronous active-low reset; clears all state immediately.
f_out  input  DIGEST_W  digest bits from the permutation state; MSB first.
f_valid  input  1  permutation finished; f_out is valid and holds until f_ack.
f_ack  output  1  one-cycle pulse when f_out is captured.
out_size  input  2  hash length select: 00 = 512, 01 = 384, 10 = 256, 11 = 224.
abort  input  1  synchronous flush; discards any digest in progress.
out  output  WORD_W  current digest word.
out_valid  output  1  out holds a valid word.
out_ready  input  1  user accepts out this cycle.
out_last  output  1  out is the final word of the digest; qualified by out_valid.
busy  output  1  a digest is loaded or being sent.

Behaviour:
- Reset values (reset_n low, asynchronous): state IDLE, shift register 0, word counter 0, f_ack 0, out 0, out_valid 0, out_last 0, busy 0.
- Word count N is decoded from out_size: 16, 12, 8, 7. The 224-bit hash is exactly 7 words, so no partial word ever occurs.
- The FSM has two states, IDLE and SEND.
- IDLE -> SEND:
  - Taken when f_valid=1 and abort=0 at edge T.
  - At T: the shift register loads f_out, the counter loads N, and out_size is latched.
  - f_ack is high for exactly the cycle after T.
  - out_valid=1 from the cycle after T, so latency from f_valid to the first word is 1 cycle.
- SEND, word output:
  - out = shift register[DIGEST_W-1 -: WORD_W].
  - Word k of the digest is f_out[DIGEST_W-1-32k -: 32].
- SEND, transfer:
  - A transfer happens on an edge where out_valid & out_ready are both high.
  - On a transfer: shift left by WORD_W (zero fill) and decrement the counter.
  - out_last = (counter == 1).
- SEND -> IDLE: on the transfer where out_last=1. out_valid is 0 in the next cycle.
- Back-to-back digests: in IDLE, f_valid is sampled again from the first cycle after the return. Minimum gap between the last word of one digest and the first word of the next is 1 idle cycle.
- Backpressure: while out_valid=1 and out_ready=0, out and out_last hold stable. out_valid never drops without a transfer, except on abort or reset.
- f_valid in SEND: ignored. There is no f_ack until the FSM returns to IDLE and samples f_valid again.
- out_size changes in SEND: ignored; the latched value governs the current digest.
- abort (any state, priority over everything except reset):
  - Next state IDLE, out_valid=0, counter=0, f_ack=0.
  - If f_valid and abort are high at the same edge, f_ack is not issued.
- busy = (state == SEND).
- Counter width: clog2(DIGEST_W/WORD_W + 1) = 5 bits. It never wraps: decrement only happens while counter >= 1.
- Reset asserted mid-SEND: all outputs drop asynchronously, and any partially sent digest is lost.

Decomposition:
- Shared package keccak_pkg holds:
  - out_size encodings: SIZE_512=2'b00, SIZE_384=2'b01, SIZE_256=2'b10, SIZE_224=2'b11. These match the padder.
  - Word-count constants: 16/12/8/7.
  - FSM state enum.
- No sub-module is needed. The size-to-word-count decode is a small function in the package, shared with the padder bitrate decode.

Test Plan:
1. out_size=00, f_out = 512'h000102…3F pattern, out_ready=1 always:
   - f_ack pulses 1 cycle after f_valid.
   - 16 words on consecutive cycles, first word 32'h00010203, last word 32'h3C3D3E3F.
   - out_last only on word 16; out_valid=0 the next cycle.
2. out_size=11, same f_out: exactly 7 words, last word 32'h18191A1B with out_last=1.
3. out_size=10, out_ready toggled 1,0,0,1…:
   - out is stable during every ready=0 cycle.
   - 8 transfers total, word order unchanged.
4. out_size=01, f_valid held high through SEND with a new f_out:
   - 12 words sent, no second f_ack before out_last.
   - Second digest acked 1 cycle after returning to IDLE and streamed correctly.
5. abort after word 3 of a 512-bit digest: out_valid=0 next cycle, busy=0; the next f_valid streams a fresh digest from word 0.
6. reset_n pulsed low mid-SEND, asynchronously between edges:
   - out_valid, f_ack and busy drop immediately.
   - After release, idle until f_valid.
